// File: rtl/clk_meas_pkg.sv
// Shared types and default sizing for the clock period meter.
// Optional duty-cycle output is enabled by CLK_PERIOD_METER_DUTY_EN.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int CNT_W_DEF   = 28;
    localparam int TIMEOUT_DEF = 10_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input plus rising-edge
// detection against a history flop; reusable by any block.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], sig};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~hist;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow square wave in system clock cycles.
// Define CLK_PERIOD_METER_DUTY_EN to add the high_o high-time output.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_10MHz_i,
    input  logic             rst_i,
    input  logic             sig_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             busy_o
`ifdef CLK_PERIOD_METER_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_o
`endif
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             level;
    logic             rise;
    logic             hit;
    logic             clear;
    logic             take;
    logic             expire;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk_10MHz_i),
        .rst  (rst_i),
        .sig  (sig_i),
        .level(level),
        .rise (rise)
    );

    assign hit = (count == LIMIT);

    always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (rise) state_nxt = MEASURE;
                MEASURE: if (!rise && hit) state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A rise in the same cycle as the limit is a measurement, not a timeout.
    always_comb begin
        clear  = !enable_i || (state == IDLE);
        take   = !clear && (state == MEASURE) && rise;
        expire = !clear && !rise && hit;
    end

    always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
        if (rst_i) begin
            count     <= '0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            if (clear)       count <= '0;
            else if (rise)   count <= ONE;
            else if (hit)    count <= '0;
            else             count <= count + ONE;
            if (take) period_o <= count;
            valid_o <= take;
            if (!enable_i || take) timeout_o <= 1'b0;
            else if (expire)       timeout_o <= 1'b1;
            busy_o <= (state_nxt != IDLE);
        end
    end

`ifdef CLK_PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] high_cnt;

    // High time counts the rise cycle itself, matching the period counter.
    always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
        if (rst_i) begin
            high_cnt <= '0;
            high_o   <= '0;
        end else begin
            if (clear)                 high_cnt <= '0;
            else if (rise)             high_cnt <= ONE;
            else if (state == MEASURE) high_cnt <= high_cnt + CNT_W'(level);
            else                       high_cnt <= '0;
            if (take) high_o <= high_cnt;
        end
    end
`else
    logic level_unused;
    assign level_unused = level;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomised and directed bench for clk_period_meter against an
// edge-time reference model; honours CLK_PERIOD_METER_DUTY_EN.
`timescale 1ns/1ps
module tb_clk_period_meter;

    localparam int CW = 28;
    localparam int TO = 100;
    localparam int SS = 2;

    logic          clk;
    logic          rst;
    logic          sig;
    logic          en;
    logic [CW-1:0] period;
    logic          valid;
    logic          tmo;
    logic          busy;
`ifdef CLK_PERIOD_METER_DUTY_EN
    logic [CW-1:0] high;
`endif

    int n_tests;
    int n_fail;

    clk_period_meter #(
        .CNT_W      (CW),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_10MHz_i(clk),
        .rst_i      (rst),
        .sig_i      (sig),
        .enable_i   (en),
        .period_o   (period),
        .valid_o    (valid),
        .timeout_o  (tmo),
        .busy_o     (busy)
`ifdef CLK_PERIOD_METER_DUTY_EN
        ,
        .high_o     (high)
`endif
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks edge indices, derives periods by subtraction.
    int  m;
    int  ref_edge;
    int  hi;
    bit  active;
    bit  meas;
    bit  samp [1:SS+1];
    int  e_period;
    int  e_high;
    bit  e_valid;
    bit  e_to;
    bit  e_busy;

    initial begin
        m = 0; ref_edge = 0; hi = 0; active = 0; meas = 0;
        e_period = 0; e_high = 0; e_valid = 0; e_to = 0; e_busy = 0;
        for (int k = 1; k <= SS + 1; k++) samp[k] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                active = 0; meas = 0; hi = 0;
                e_period = 0; e_high = 0; e_valid = 0; e_to = 0; e_busy = 0;
                for (int k = 1; k <= SS + 1; k++) samp[k] = 0;
            end else begin
                bit r;
                bit lvl;
                int hprev;
                m++;
                r     = samp[SS] & ~samp[SS+1];
                lvl   = samp[SS];
                hprev = hi;
                if (active && en) hi = r ? 1 : hi + int'(lvl);
                e_valid = 0;
                if (!active) begin
                    if (en) begin
                        active = 1; meas = 0; ref_edge = m + 1;
                    end
                end else if (!en) begin
                    active = 0; meas = 0; e_to = 0;
                end else if (r) begin
                    if (meas) begin
                        e_period = m - ref_edge;
                        e_high   = hprev;
                        e_valid  = 1;
                        e_to     = 0;
                    end
                    meas = 1; ref_edge = m;
                end else if (m - ref_edge == TO) begin
                    e_to = 1; meas = 0; ref_edge = m + 1;
                end
                e_busy = active;
                for (int k = SS + 1; k >= 2; k--) samp[k] = samp[k-1];
                samp[1] = sig;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("period", 32'(period), 32'(e_period));
            check("valid", 32'(valid), 32'(e_valid));
            check("timeout", 32'(tmo), 32'(e_to));
            check("busy", 32'(busy), 32'(e_busy));
`ifdef CLK_PERIOD_METER_DUTY_EN
            if (e_valid) check("high", 32'(high), 32'(e_high));
`endif
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            @(negedge clk); sig = 1'b1;
            cycles(h - 1);
            @(negedge clk); sig = 1'b0;
            cycles(l - 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        cycles(3);
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        sig = 1'b0;
        en  = 1'b0;
        do_reset();
        cycles(2);
        check("rst_period", 32'(period), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        en = 1'b1;
        wave(11, 11, 8);
        check("t1_p22", 32'(period), 32'd22);

        do_reset();
        en = 1'b1;
        cycles(TO + 20);
        check("t2_to", 32'(tmo), 32'd1);
        check("t2_p0", 32'(period), 32'd0);
        wave(11, 11, 4);
        check("t2_clr", 32'(tmo), 32'd0);
        check("t2_p22", 32'(period), 32'd22);

        wave(11, 11, 3);
        wave(21, 21, 5);
        check("t3_p42", 32'(period), 32'd42);

        @(negedge clk); sig = 1'b1;
        cycles(SS + 1 + 5);
        en = 1'b0;
        cycles(2);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_hold", 32'(period), 32'd42);
        sig = 1'b0;
        cycles(5);
        en = 1'b1;
        wave(21, 21, 3);

        wave(11, 11, 2);
        @(negedge clk); sig = 1'b1;
        cycles(4);
        #10 rst = 1'b1;
        #1;
        check("t5_period", 32'(period), 32'd0);
        check("t5_valid", 32'(valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_to", 32'(tmo), 32'd0);
        @(negedge clk); rst = 1'b0; sig = 1'b0;
        wave(11, 11, 4);
        check("t5_p22", 32'(period), 32'd22);

        wave(6, 16, 4);
        check("t6_p22", 32'(period), 32'd22);
`ifdef CLK_PERIOD_METER_DUTY_EN
        check("t6_high", 32'(high), 32'd6);
`endif

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                @(negedge clk); en = 1'b0;
                cycles(int'($urandom_range(1, 6)));
                @(negedge clk); en = 1'b1;
            end else if (sel == 1) begin
                @(negedge clk); sig = 1'b0;
                cycles(int'($urandom_range(TO - 10, TO + 60)));
            end else begin
                wave(int'($urandom_range(1, 55)), int'($urandom_range(1, 55)),
                     int'($urandom_range(1, 4)));
            end
        end
        cycles(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
